// File: rtl/logic_result_stage.sv
// Result stage of the ALU logic unit: picks one of four logic results, flags zero,
// and holds it in a two-entry skid buffer in front of the EX/MEM boundary.
module logic_result_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] and_res,
  input  logic [DATA_W-1:0] or_res,
  input  logic [DATA_W-1:0] nor_res,
  input  logic [DATA_W-1:0] xor_res,
  input  logic [1:0]        logic_op,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              wen_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              flush,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] rd_out,
  output logic              wen_out,
  output logic              zero_out,
  output logic [7:0]        drop_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // on both sides valid may not depend combinationally on ready.

  // State encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  state_t state_q, state_d;

  // Slot 0 is always the head; slot 1 holds the younger entry when full.
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [REG_AW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic              wen0_q, wen0_d, wen1_q, wen1_d;
  logic              zero0_q, zero0_d, zero1_q, zero1_d;
  logic              ready_q, ready_d;
  logic [7:0]        drop_q, drop_d;

  logic [DATA_W-1:0] sel_data;
  logic              sel_zero;
  logic              push;
  logic              pop;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic [1:0]        kill;
  logic [8:0]        drop_sum;

  always_comb begin
    sel_data = and_res;
    case (logic_op)
      2'b00:   sel_data = and_res;
      2'b01:   sel_data = or_res;
      2'b10:   sel_data = nor_res;
      2'b11:   sel_data = xor_res;
      default: sel_data = and_res;
    endcase
  end

  assign sel_zero  = (sel_data == '0);
  assign valid_out = (state_q != ST_EMPTY);
  assign push      = valid_in & ready_q;
  assign pop       = valid_out & ready_out;
  assign cnt_q     = state_q;
  assign cnt_d     = state_d;

  // A head popped in the flush cycle was delivered, so it is not a drop.
  assign kill     = cnt_q - {1'b0, pop};
  assign drop_sum = {1'b0, drop_q} + {7'b0, kill};

  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    rd0_d   = rd0_q;
    wen0_d  = wen0_q;
    zero0_d = zero0_q;
    data1_d = data1_q;
    rd1_d   = rd1_q;
    wen1_d  = wen1_q;
    zero1_d = zero1_q;
    drop_d  = drop_q;

    if (flush) begin
      state_d = ST_EMPTY;
      drop_d  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            data0_d = sel_data;
            rd0_d   = rd_in;
            wen0_d  = wen_in;
            zero0_d = sel_zero;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            data0_d = sel_data;
            rd0_d   = rd_in;
            wen0_d  = wen_in;
            zero0_d = sel_zero;
          end else if (push) begin
            data1_d = sel_data;
            rd1_d   = rd_in;
            wen1_d  = wen_in;
            zero1_d = sel_zero;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            data0_d = data1_q;
            rd0_d   = rd1_q;
            wen0_d  = wen1_q;
            zero0_d = zero1_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    ready_d = (cnt_d < FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data0_q <= '0;
      rd0_q   <= '0;
      wen0_q  <= 1'b0;
      zero0_q <= 1'b0;
      data1_q <= '0;
      rd1_q   <= '0;
      wen1_q  <= 1'b0;
      zero1_q <= 1'b0;
      ready_q <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      data0_q <= data0_d;
      rd0_q   <= rd0_d;
      wen0_q  <= wen0_d;
      zero0_q <= zero0_d;
      data1_q <= data1_d;
      rd1_q   <= rd1_d;
      wen1_q  <= wen1_d;
      zero1_q <= zero1_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
    end
  end

  assign ready_in = ready_q;
  assign result   = data0_q;
  assign rd_out   = rd0_q;
  assign zero_out = zero0_q;
  assign wen_out  = valid_out & wen0_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// Bench for logic_result_stage: directed vectors feed an expected queue that a
// negedge monitor drains whenever the stage hands off a result.
module tb_logic_result_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = AW + 2 + DW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] and_res, or_res, nor_res, xor_res;
  logic [1:0]    logic_op;
  logic [AW-1:0] rd_in;
  logic          wen_in;
  logic          valid_in;
  logic          ready_in;
  logic          flush;
  logic          valid_out;
  logic          ready_out;
  logic [DW-1:0] result;
  logic [AW-1:0] rd_out;
  logic          wen_out;
  logic          zero_out;
  logic [7:0]    drop_cnt;

  // Expected entry layout: {rd, wen, zero, data}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;

  logic_result_stage #(.DATA_W(DW), .REG_AW(AW), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .and_res(and_res), .or_res(or_res), .nor_res(nor_res), .xor_res(xor_res),
    .logic_op(logic_op), .rd_in(rd_in), .wen_in(wen_in),
    .valid_in(valid_in), .ready_in(ready_in), .flush(flush),
    .valid_out(valid_out), .ready_out(ready_out),
    .result(result), .rd_out(rd_out), .wen_out(wen_out),
    .zero_out(zero_out), .drop_cnt(drop_cnt)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] o,
                      input logic [DW-1:0] n, input logic [DW-1:0] x,
                      input logic [1:0] op, input logic [AW-1:0] rd,
                      input logic w, input logic [DW-1:0] exp);
    bit acc;
    acc = 1'b0;
    and_res = a; or_res = o; nor_res = n; xor_res = x;
    logic_op = op; rd_in = rd; wen_in = w; valid_in = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
    end
    if (acc) exp_q.push_back({rd, w, (exp == '0), exp});
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: accepted=0 required accepted=1 (t=%0t)", $time);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
    logic_op = 2'bxx;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (!valid_out) chk("wen_idle", wen_out, 1'b0);
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got result 0x%0h required no output", result);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e[DW-1:0]);
          chk("zero_out", zero_out, e[DW]);
          chk("wen_out", wen_out, e[DW+1]);
          chk("rd_out", rd_out, e[EW-1:DW+2]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; flush = 1'b0; ready_out = 1'b0;
    and_res = '0; or_res = '0; nor_res = '0; xor_res = '0;
    logic_op = 2'b00; rd_in = '0; wen_in = 1'b0; valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_rd_out", rd_out, 5'd0);
    chk("rst_wen_out", wen_out, 1'b0);
    chk("rst_zero_out", zero_out, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'd0);
    chk("rst_ready_in", ready_in, 1'b0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", ready_in, 1'b1);

    // single op, latency 1
    ready_out = 1'b1;
    send(32'h0000_FF00, 32'h1, 32'h2, 32'h3, 2'b00, 5'd3, 1'b1, 32'h0000_FF00);
    idle();
    @(negedge clk);
    chk("latency_valid", valid_out, 1'b1);
    cycles(2);

    // op select sweep
    send(32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 2'b00, 5'd1, 1'b1, 32'h0);
    send(32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 2'b01, 5'd2, 1'b0, 32'hFFFF_FFFF);
    send(32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 2'b10, 5'd4, 1'b1, 32'h0);
    send(32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 2'b11, 5'd5, 1'b1, 32'hFFFF_FFFF);
    send(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b00, 5'd6, 1'b1, 32'h1111_1111);
    send(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b01, 5'd7, 1'b0, 32'h2222_2222);
    send(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b10, 5'd8, 1'b1, 32'h3333_3333);
    send(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 2'b11, 5'd9, 1'b1, 32'h4444_4444);
    idle();
    cycles(3);

    // backpressure
    ready_out = 1'b0;
    send(32'hAAAA_0001, 32'h0, 32'h0, 32'h0, 2'b00, 5'd10, 1'b1, 32'hAAAA_0001);
    send(32'h0, 32'hBBBB_0002, 32'h0, 32'h0, 2'b01, 5'd11, 1'b1, 32'hBBBB_0002);
    chk("bp_ready_low", ready_in, 1'b0);
    xor_res = 32'hCCCC_0003; logic_op = 2'b11; rd_in = 5'd12; valid_in = 1'b1;
    @(negedge clk);
    chk("bp_hold1", ready_in, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_hold2", ready_in, 1'b0);
    @(posedge clk); #1;
    idle();
    ready_out = 1'b1;
    @(negedge clk);
    chk("bp_pop_a", valid_out, 1'b1);
    @(negedge clk);
    chk("bp_pop_b", valid_out, 1'b1);
    @(negedge clk);
    chk("bp_empty", valid_out, 1'b0);
    chk("bp_ready_back", ready_in, 1'b1);
    chk("bp_queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // streaming
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      send(32'h0, 32'h0, 32'h0, 32'h5000_0000 + i, 2'b11, 5'(i + 13), i[0], 32'h5000_0000 + i);
      chk("stream_valid", valid_out, 1'b1);
    end
    chk("stream_cycles", cyc - c0, 10);
    idle();
    cycles(3);

    // flush with two entries held and a same-cycle push
    ready_out = 1'b0;
    send(32'h0000_1234, 32'h0, 32'h0, 32'h0, 2'b00, 5'd20, 1'b1, 32'h0000_1234);
    send(32'h0000_5678, 32'h0, 32'h0, 32'h0, 2'b00, 5'd21, 1'b1, 32'h0000_5678);
    and_res = 32'h0000_9999; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    exp_q.delete();
    chk("flush_valid_out", valid_out, 1'b0);
    chk("flush_wen_out", wen_out, 1'b0);
    chk("flush_drop_cnt", drop_cnt, 8'd2);
    @(negedge clk);
    chk("flush_ready_in", ready_in, 1'b1);
    @(posedge clk); #1;

    // flush while the head is popped and a push is offered
    send(32'h0000_0D0D, 32'h0, 32'h0, 32'h0, 2'b00, 5'd22, 1'b1, 32'h0000_0D0D);
    and_res = 32'h0000_0E0E; rd_in = 5'd23; valid_in = 1'b1;
    ready_out = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    exp_q.delete();
    chk("flushpop_valid_out", valid_out, 1'b0);
    chk("flushpop_drop_cnt", drop_cnt, 8'd2);
    cycles(2);
    chk("flushpop_push_absent", valid_out, 1'b0);

    // async reset while full
    ready_out = 1'b0;
    send(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 2'b00, 5'd31, 1'b1, 32'hDEAD_BEEF);
    send(32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 5'd30, 1'b1, 32'h0);
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid_out", valid_out, 1'b0);
    chk("arst_result", result, 32'h0);
    chk("arst_rd_out", rd_out, 5'd0);
    chk("arst_wen_out", wen_out, 1'b0);
    chk("arst_zero_out", zero_out, 1'b0);
    chk("arst_drop_cnt", drop_cnt, 8'd0);
    chk("arst_ready_in", ready_in, 1'b0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready_after", ready_in, 1'b1);
    chk("arst_valid_after", valid_out, 1'b0);

    // life after reset
    ready_out = 1'b1;
    send(32'h0, 32'h0, 32'h7777_0000, 32'h0, 2'b10, 5'd17, 1'b1, 32'h7777_0000);
    idle();
    cycles(3);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
